// File: rtl/accel_arith_pkg.sv
// Shared arithmetic definitions for the accelerator datapath: the flag
// bundle produced by the add/sub pipeline, the per-stage chunk width and
// a parameter sanity check used at elaboration time.
package accel_arith_pkg;

    // Carry out of the MSB and signed overflow travel together.
    typedef struct packed {
        logic carry;
        logic ovf;
    } flags_t;

    // Width of one lookahead slice; guarded so a bad STAGES value still
    // reaches the readable error in paramsOk instead of a divide by zero.
    function automatic int chunkWidth(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // The pipeline only works when the word splits into equal slices.
    function automatic bit paramsOk(input int width, input int stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// One lookahead slice of the pipelined adder. Purely combinational: it
// takes the operand slices and the carry entering the slice, and returns
// the slice sum, the carry leaving the slice and the carry entering its
// top bit (the last slice uses that one for signed overflow).
module cla_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         c_msb_in_o
);

    logic [N-1:0] prop;
    logic [N-1:0] gen;
    logic [N:0]   carry;

    assign prop = a_i ^ b_i;
    assign gen  = a_i & b_i;

    // Generate/propagate carry recurrence across the slice.
    always_comb begin
        carry[0] = cin_i;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign sum_o      = prop ^ carry[N-1:0];
    assign cout_o     = carry[N];
    assign c_msb_in_o = carry[N-1];

endmodule

// File: rtl/pipelined_lookahead_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// The word is split into STAGES equal slices; stage k adds slice k using
// the carry registered by stage k-1. Operand slices not yet consumed ride
// forward in skew registers and finished sum slices ride forward in delay
// registers, so the whole result lines up in the last stage, which drives
// the outputs directly. A stalled output freezes every stage at once.
module pipelined_lookahead_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    import accel_arith_pkg::*;

    localparam int CHUNK = chunkWidth(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if (!paramsOk(WIDTH, STAGES)) begin : gBadParams
        $error("pipelined_lookahead_addsub: STAGES must be >= 1 and divide WIDTH");
    end

    // Values entering each stage (from the ports for stage 0, otherwise
    // from the previous stage's registers) and what each stage produces.
    logic [WIDTH-1:0] aIn      [STAGES];
    logic [WIDTH-1:0] bIn      [STAGES];
    logic [WIDTH-1:0] sumIn    [STAGES];
    logic             cIn      [STAGES];
    logic [TAG_W-1:0] tagIn    [STAGES];
    logic             vIn      [STAGES];
    logic [CHUNK-1:0] chunkSum [STAGES];
    logic             chunkCout[STAGES];
    logic             chunkCMsb[STAGES];
    logic [WIDTH-1:0] sum_d    [STAGES];
    flags_t           flags_d  [STAGES];

    // Per-stage pipeline registers.
    logic             valid_q[STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] sum_q  [STAGES];
    flags_t           flags_q[STAGES];
    logic [TAG_W-1:0] tag_q  [STAGES];

    logic advance;

    // The only stall source is a held result at the output; when it is
    // present every stage freezes and the entry refuses new work.
    assign advance  = ~(valid_q[LAST] & ~out_ready);
    assign in_ready = advance;

    for (genvar s = 0; s < STAGES; s++) begin : gStage
        if (s == 0) begin : gEntry
            // Subtraction is A + ~B + ~borrow, folded in before slice 0.
            assign aIn[s]   = in_a;
            assign bIn[s]   = in_sub ? ~in_b : in_b;
            assign cIn[s]   = in_cin ^ in_sub;
            assign sumIn[s] = '0;
            assign tagIn[s] = in_tag;
            assign vIn[s]   = in_valid;
        end else begin : gSkew
            assign aIn[s]   = a_q[s-1];
            assign bIn[s]   = b_q[s-1];
            assign cIn[s]   = flags_q[s-1].carry;
            assign sumIn[s] = sum_q[s-1];
            assign tagIn[s] = tag_q[s-1];
            assign vIn[s]   = valid_q[s-1];
        end

        cla_chunk #(
            .N(CHUNK)
        ) uChunk (
            .a_i       (aIn[s][s*CHUNK +: CHUNK]),
            .b_i       (bIn[s][s*CHUNK +: CHUNK]),
            .cin_i     (cIn[s]),
            .sum_o     (chunkSum[s]),
            .cout_o    (chunkCout[s]),
            .c_msb_in_o(chunkCMsb[s])
        );

        // Upper sum slices are still zero here, so OR-ing places the new slice.
        assign sum_d[s]   = sumIn[s] | (WIDTH'(chunkSum[s]) << (s * CHUNK));
        assign flags_d[s] = '{carry: chunkCout[s], ovf: chunkCMsb[s] ^ chunkCout[s]};
    end

    // Shift all stages together; payload only moves with a valid op so idle
    // stages keep their last contents instead of picking up bus noise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                a_q[s]     <= '0;
                b_q[s]     <= '0;
                sum_q[s]   <= '0;
                flags_q[s] <= '0;
                tag_q[s]   <= '0;
            end
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= vIn[s];
                if (vIn[s]) begin
                    a_q[s]     <= aIn[s];
                    b_q[s]     <= bIn[s];
                    sum_q[s]   <= sum_d[s];
                    flags_q[s] <= flags_d[s];
                    tag_q[s]   <= tagIn[s];
                end
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_carry = flags_q[LAST].carry;
    assign out_ovf   = flags_q[LAST].ovf;
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_pipelined_lookahead_addsub.sv
// Directed bench for the pipelined adder/subtractor. Three copies of the
// design (STAGES = 4, 1 and 16) have private stimulus and are exercised one
// after the other by the same scenario tasks.
module tb_pipelined_lookahead_addsub;

    logic        clk;
    logic        rst      [3];
    logic        inValid  [3];
    logic        inReady  [3];
    logic [15:0] inA      [3];
    logic [15:0] inB      [3];
    logic        inCin    [3];
    logic        inSub    [3];
    logic [3:0]  inTag    [3];
    logic        outValid [3];
    logic        outReady [3];
    logic [15:0] outSum   [3];
    logic        outCarry [3];
    logic        outOvf   [3];
    logic [3:0]  outTag   [3];

    int latTab[3] = '{4, 1, 16};
    int checkCount = 0;
    int passCount  = 0;

    pipelined_lookahead_addsub #(.WIDTH(16), .STAGES(4), .TAG_W(4)) uDut4 (
        .clk(clk), .rst(rst[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_a(inA[0]), .in_b(inB[0]), .in_cin(inCin[0]), .in_sub(inSub[0]), .in_tag(inTag[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_sum(outSum[0]),
        .out_carry(outCarry[0]), .out_ovf(outOvf[0]), .out_tag(outTag[0])
    );

    pipelined_lookahead_addsub #(.WIDTH(16), .STAGES(1), .TAG_W(4)) uDut1 (
        .clk(clk), .rst(rst[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_a(inA[1]), .in_b(inB[1]), .in_cin(inCin[1]), .in_sub(inSub[1]), .in_tag(inTag[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_sum(outSum[1]),
        .out_carry(outCarry[1]), .out_ovf(outOvf[1]), .out_tag(outTag[1])
    );

    pipelined_lookahead_addsub #(.WIDTH(16), .STAGES(16), .TAG_W(4)) uDut16 (
        .clk(clk), .rst(rst[2]), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_a(inA[2]), .in_b(inB[2]), .in_cin(inCin[2]), .in_sub(inSub[2]), .in_tag(inTag[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .out_sum(outSum[2]),
        .out_carry(outCarry[2]), .out_ovf(outOvf[2]), .out_tag(outTag[2])
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 17-bit add; overflow from operand/result sign rule.
    function automatic logic [21:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub, input logic [3:0] tag);
        logic [15:0] be;
        logic [16:0] full;
        logic        ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + 17'(cin ^ sub);
        ovf  = (a[15] == be[15]) && (full[15] != a[15]);
        return {full[15:0], full[16], ovf, tag};
    endfunction

    // Deterministic stream vectors with a few edge operands mixed in.
    function automatic logic [15:0] vecA(input int i);
        logic [15:0] v;
        v = 16'(i * 15197 + 291);
        if (i % 5 == 2) v = 16'hFFFF;
        if (i % 7 == 4) v = 16'h7FFF;
        return v;
    endfunction

    function automatic logic [15:0] vecB(input int i);
        logic [15:0] v;
        v = 16'((i * 9277) ^ 32769);
        if (i % 7 == 4) v = 16'h0001;
        return v;
    endfunction

    // Issues one op into an empty pipe and waits for its result; returns
    // the latency in cycles from acceptance plus the observed outputs.
    task automatic runOp(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [3:0] tag,
                         output int lat, output logic [21:0] res);
        inA[d] = a; inB[d] = b; inCin[d] = cin; inSub[d] = sub; inTag[d] = tag;
        inValid[d]  = 1'b1;
        outReady[d] = 1'b1;
        @(posedge clk); #1;
        inValid[d] = 1'b0;
        lat = 1;
        while (!outValid[d] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {outSum[d], outCarry[d], outOvf[d], outTag[d]};
        @(posedge clk); #1;
    endtask

    task automatic test_reset(input int d);
        rst[d] = 1'b1; inValid[d] = 1'b0; outReady[d] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkCount++;
        if (outValid[d] !== 1'b0) $display("[TB] FAIL dut%0d reset out_valid: got %b expected 0", d, outValid[d]);
        else passCount++;
        checkCount++;
        if ({outSum[d], outCarry[d], outOvf[d], outTag[d]} !== 22'h0)
            $display("[TB] FAIL dut%0d reset outputs: got %h expected 000000", d,
                     {outSum[d], outCarry[d], outOvf[d], outTag[d]});
        else passCount++;
        rst[d] = 1'b0;
        @(posedge clk); #1;
        checkCount++;
        if (inReady[d] !== 1'b1) $display("[TB] FAIL dut%0d in_ready after reset: got %b expected 1", d, inReady[d]);
        else passCount++;
        outReady[d] = 1'b1;
    endtask

    task automatic test_single(input int d);
        int lat;
        logic [21:0] res;
        runOp(d, 16'h00FF, 16'h0001, 1'b0, 1'b0, 4'd3, lat, res);
        checkCount++;
        if (lat !== latTab[d]) $display("[TB] FAIL dut%0d single latency: got %0d expected %0d", d, lat, latTab[d]);
        else passCount++;
        checkCount++;
        if (res[21:6] !== 16'h0100) $display("[TB] FAIL dut%0d single sum: got %h expected 0100", d, res[21:6]);
        else passCount++;
        checkCount++;
        if (res[5:4] !== 2'b00) $display("[TB] FAIL dut%0d single carry/ovf: got %b expected 00", d, res[5:4]);
        else passCount++;
        checkCount++;
        if (res[3:0] !== 4'd3) $display("[TB] FAIL dut%0d single tag: got %0d expected 3", d, res[3:0]);
        else passCount++;
    endtask

    task automatic test_carry_ripple(input int d);
        int lat;
        logic [21:0] res;
        runOp(d, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 4'd5, lat, res);
        checkCount++;
        if (res !== {16'h0000, 1'b1, 1'b0, 4'd5})
            $display("[TB] FAIL dut%0d ripple: got %h expected %h", d, res, {16'h0000, 1'b1, 1'b0, 4'd5});
        else passCount++;
    endtask

    task automatic test_sub_ovf(input int d);
        logic [15:0] ta[7] = '{16'h0005, 16'h7FFF, 16'h8000, 16'h0000, 16'h0010, 16'h8000, 16'h1234};
        logic [15:0] tb[7] = '{16'h0007, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h1234};
        logic        tc[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ts[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] es[7] = '{16'hFFFE, 16'h8000, 16'h7FFF, 16'h0000, 16'h000E, 16'h0000, 16'h0000};
        logic        ec[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        eo[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        logic [21:0] res;
        logic [21:0] exp;
        for (int i = 0; i < 7; i++) begin
            runOp(d, ta[i], tb[i], tc[i], ts[i], 4'(i), lat, res);
            exp = {es[i], ec[i], eo[i], 4'(i)};
            checkCount++;
            if (res !== exp) $display("[TB] FAIL dut%0d addsub vec%0d: got %h expected %h", d, i, res, exp);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [21:0] expQ[$];
        logic [21:0] got;
        logic [21:0] exp;
        int sent = 0;
        int recv = 0;
        int firstCyc = -1;
        int lastCyc = -1;
        outReady[d] = 1'b1;
        for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
            inValid[d] = (sent < 20);
            inA[d] = vecA(sent); inB[d] = vecB(sent);
            inCin[d] = 1'((sent >> 1) & 1); inSub[d] = 1'(sent ^ (sent >> 2)); inTag[d] = 4'(sent);
            @(negedge clk);
            if (outValid[d] && outReady[d]) begin
                got = {outSum[d], outCarry[d], outOvf[d], outTag[d]};
                exp = (expQ.size() > 0) ? expQ.pop_front() : 22'h3FFFFF;
                checkCount++;
                if (got !== exp) $display("[TB] FAIL dut%0d stream result %0d: got %h expected %h", d, recv, got, exp);
                else passCount++;
                if (firstCyc < 0) firstCyc = cyc;
                lastCyc = cyc;
                recv++;
            end
            if (inValid[d] && inReady[d]) begin
                expQ.push_back(model(inA[d], inB[d], inCin[d], inSub[d], inTag[d]));
                sent++;
            end
            @(posedge clk); #1;
        end
        inValid[d] = 1'b0;
        checkCount++;
        if (recv !== 20) $display("[TB] FAIL dut%0d stream count: got %0d expected 20", d, recv);
        else passCount++;
        checkCount++;
        if (firstCyc !== latTab[d]) $display("[TB] FAIL dut%0d stream first cycle: got %0d expected %0d", d, firstCyc, latTab[d]);
        else passCount++;
        checkCount++;
        if (lastCyc - firstCyc !== 19) $display("[TB] FAIL dut%0d stream span: got %0d expected 19", d, lastCyc - firstCyc);
        else passCount++;
    endtask

    task automatic test_backpressure(input int d);
        logic [21:0] expQ[$];
        logic [22:0] snap;
        logic [22:0] now;
        logic [21:0] got;
        logic [21:0] exp;
        int total = latTab[d] + 6;
        int stallStart = latTab[d] + 1;
        int sent = 0;
        int recv = 0;
        bit inStall;
        for (int cyc = 0; cyc < 300 && recv < total; cyc++) begin
            inStall = (cyc >= stallStart) && (cyc < stallStart + 5);
            outReady[d] = !inStall;
            inValid[d] = (sent < total);
            inA[d] = vecA(sent + 40); inB[d] = vecB(sent + 40);
            inCin[d] = 1'(sent & 1); inSub[d] = 1'((sent >> 1) & 1); inTag[d] = 4'(sent + 7);
            @(negedge clk);
            now = {outValid[d], outSum[d], outCarry[d], outOvf[d], outTag[d]};
            if (inStall) begin
                checkCount++;
                if (inReady[d] !== 1'b0) $display("[TB] FAIL dut%0d stall in_ready cyc%0d: got %b expected 0", d, cyc, inReady[d]);
                else passCount++;
                if (cyc == stallStart) begin
                    snap = now;
                    checkCount++;
                    if (snap[22] !== 1'b1) $display("[TB] FAIL dut%0d stall holds result: got %b expected 1", d, snap[22]);
                    else passCount++;
                end else begin
                    checkCount++;
                    if (now !== snap) $display("[TB] FAIL dut%0d stall stable cyc%0d: got %h expected %h", d, cyc, now, snap);
                    else passCount++;
                end
            end
            if (outValid[d] && outReady[d]) begin
                got = now[21:0];
                exp = (expQ.size() > 0) ? expQ.pop_front() : 22'h3FFFFF;
                checkCount++;
                if (got !== exp) $display("[TB] FAIL dut%0d backpressure result %0d: got %h expected %h", d, recv, got, exp);
                else passCount++;
                recv++;
            end
            if (inValid[d] && inReady[d]) begin
                expQ.push_back(model(inA[d], inB[d], inCin[d], inSub[d], inTag[d]));
                sent++;
            end
            @(posedge clk); #1;
        end
        inValid[d] = 1'b0;
        outReady[d] = 1'b1;
        checkCount++;
        if (recv !== total) $display("[TB] FAIL dut%0d backpressure count: got %0d expected %0d", d, recv, total);
        else passCount++;
    endtask

    task automatic test_reset_midflight(input int d);
        int seen = 0;
        outReady[d] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inA[d] = 16'h1111 * 16'(i + 1); inB[d] = 16'h0F0F;
            inCin[d] = 1'b0; inSub[d] = 1'b0; inTag[d] = 4'(i + 9);
            inValid[d] = 1'b1;
            @(posedge clk); #1;
        end
        inValid[d] = 1'b0;
        rst[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        checkCount++;
        if (outValid[d] !== 1'b0) $display("[TB] FAIL dut%0d midflight reset out_valid: got %b expected 0", d, outValid[d]);
        else passCount++;
        checkCount++;
        if ({outSum[d], outCarry[d], outOvf[d], outTag[d]} !== 22'h0)
            $display("[TB] FAIL dut%0d midflight reset outputs: got %h expected 000000", d,
                     {outSum[d], outCarry[d], outOvf[d], outTag[d]});
        else passCount++;
        for (int i = 0; i < latTab[d] + 4; i++) begin
            @(posedge clk); #1;
            if (outValid[d]) seen++;
        end
        checkCount++;
        if (seen !== 0) $display("[TB] FAIL dut%0d stale results after reset: got %0d expected 0", d, seen);
        else passCount++;
    endtask

    // Run every scenario on each pipeline depth in turn.
    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; inValid[d] = 1'b0; outReady[d] = 1'b1;
            inA[d] = '0; inB[d] = '0; inCin[d] = 1'b0; inSub[d] = 1'b0; inTag[d] = '0;
        end
        for (int d = 0; d < 3; d++) begin
            $display("[TB] scenarios for STAGES=%0d", latTab[d]);
            test_reset(d);
            test_single(d);
            test_carry_ripple(d);
            test_sub_ovf(d);
            test_back_to_back(d);
            test_backpressure(d);
            test_reset_midflight(d);
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
